// File: rtl/motion_update_broadcast_arbiter.sv
// Sequences one motion-update pass: round-robin shares the broadcast bus among NUM_REQ units.
// Define MU_ARB_STATS_EN to add the out_beat_count per-pass beat counter output.
module motion_update_broadcast_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CELL_ID_WIDTH = 4,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*3*DATA_WIDTH-1:0]      req_data,
    input  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0]   req_dst_cell,
    input  logic [NUM_REQ-1:0]                   req_done,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 out_motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]              out_data,
    output logic [3*CELL_ID_WIDTH-1:0]           out_dst_cell,
    output logic                                 out_data_valid,
    output logic                                 out_busy,
`ifdef MU_ARB_STATS_EN
    output logic                                 out_update_done,
    output logic [31:0]                          out_beat_count
`else
    output logic                                 out_update_done
`endif
);

    localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PAY_W    = 3 * DATA_WIDTH;
    localparam int unsigned DST_W    = 3 * CELL_ID_WIDTH;
    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StSettle, StDone} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d, grant_idx, scan_idx;
    logic [NUM_REQ-1:0]  done_q, done_d, grant;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [PAY_W-1:0]    sel_data;
    logic [DST_W-1:0]    sel_dst;
    logic                found, xfer, start_accept, done_all, others_valid;

    // Round-robin scan starting at the pointer; grants only while running.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        scan_idx  = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && req_valid[scan_idx]) begin
                found            = 1'b1;
                grant[scan_idx]  = 1'b1;
                grant_idx        = scan_idx;
            end
        end
        if (state_q != StRun) begin
            grant = '0;
        end
    end

    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);

    always_comb begin
        sel_data = '0;
        sel_dst  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*PAY_W +: PAY_W];
                sel_dst  = req_dst_cell[i*DST_W +: DST_W];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    assign start_accept = (state_q == StIdle) && start;
    assign done_d       = start_accept ? '0 : (done_q | req_done);
    assign done_all     = &(done_q | req_done);
    // A valid being granted this cycle is its final beat if everyone is done.
    assign others_valid = |(req_valid & ~grant);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                if (done_all && !others_valid) state_d = StDrain;
            end
            StDrain: begin
                state_d  = StSettle;
                settle_d = '0;
            end
            StSettle: begin
                if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) state_d = StDone;
                else settle_d = settle_q + 1'b1;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign out_motion_update_enable = (state_q == StRun) || (state_q == StDrain);
    assign out_busy                 = (state_q != StIdle);
    assign out_update_done          = (state_q == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            ptr_q          <= '0;
            done_q         <= '0;
            settle_q       <= '0;
            out_data       <= '0;
            out_dst_cell   <= '0;
            out_data_valid <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            done_q         <= done_d;
            settle_q       <= settle_d;
            out_data_valid <= xfer;
            if (xfer) begin
                out_data     <= sel_data;
                out_dst_cell <= sel_dst;
            end
        end
    end

`ifdef MU_ARB_STATS_EN
    logic [31:0] beat_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count_q <= '0;
        end else if (start_accept) begin
            beat_count_q <= '0;
        end else if (xfer && (beat_count_q != '1)) begin
            beat_count_q <= beat_count_q + 32'd1;
        end
    end

    assign out_beat_count = beat_count_q;
`endif

endmodule
